coin_accum_vend: RTL and testbench

- Parametrised successor to the two-coin 70-cent counter.
- Accepts nickels, dimes and quarters, one coin per cycle, and accumulates credit in nickel units.
- Emits a one-cycle vend pulse when credit reaches PRICE_UNITS.
- Pays back all excess as serial one-cycle nickel pulses while refusing new coins.
- Sits between the coin-detect front end and the dispense/change actuators.

---
 rtl/coin_accum_vend.sv | 123 ++++++++++++
 tb/tb_coin_accum_vend.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/coin_accum_vend.sv
// Coin accumulator: sums nickel/dime/quarter credit, pulses dollar at PRICE_UNITS, pays excess as nickel pulses.
// Optional COIN_REFUND_EN macro adds a refund input that returns all held credit as nickels.
module coin_accum_vend #(
    parameter int PRICE_UNITS = 14,
    parameter int CREDIT_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
`ifdef COIN_REFUND_EN
    input  logic                refund,
`endif
    output logic                dollar,
    output logic                nickel,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } state_t;

    localparam logic [CREDIT_W:0] PRICE_V = (CREDIT_W + 1)'(PRICE_UNITS);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_cnt_q, change_cnt_d;
    logic                dollar_q, dollar_d;
    logic                nickel_q, nickel_d;
    logic                reject_q, reject_d;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                refund_req;

`ifdef COIN_REFUND_EN
    assign refund_req = refund;
`else
    assign refund_req = 1'b0;
`endif

    always_comb begin
        coin_val = '0;
        case (coin_type)
            2'b00:   coin_val = (CREDIT_W + 1)'(1);
            2'b01:   coin_val = (CREDIT_W + 1)'(2);
            2'b10:   coin_val = (CREDIT_W + 1)'(5);
            default: coin_val = '0;
        endcase
    end

    // One extra bit so the overpayment case cannot wrap before the compare.
    assign sum = {1'b0, credit_q} + coin_val;

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        change_cnt_d = change_cnt_q;
        dollar_d     = 1'b0;
        nickel_d     = 1'b0;
        reject_d     = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (refund_req) begin
                        change_cnt_d = credit_q;
                        credit_d     = '0;
                        reject_d     = coin_valid;
                        if (credit_q != '0) state_d = CHANGE;
                    end else if (coin_valid) begin
                        if (coin_type == 2'b11) begin
                            reject_d = 1'b1;
                        end else if (sum < PRICE_V) begin
                            credit_d = sum[CREDIT_W-1:0];
                        end else begin
                            dollar_d     = 1'b1;
                            credit_d     = '0;
                            change_cnt_d = sum[CREDIT_W-1:0] - PRICE_V[CREDIT_W-1:0];
                            if (sum != PRICE_V) state_d = CHANGE;
                        end
                    end
                end
                CHANGE: begin
                    // Coins arriving while paying out are handed straight back.
                    nickel_d     = 1'b1;
                    reject_d     = coin_valid;
                    change_cnt_d = change_cnt_q - 1'b1;
                    if (change_cnt_q == CREDIT_W'(1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            change_cnt_q <= '0;
            dollar_q     <= 1'b0;
            nickel_q     <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            change_cnt_q <= change_cnt_d;
            dollar_q     <= dollar_d;
            nickel_q     <= nickel_d;
            reject_q     <= reject_d;
        end
    end

    assign dollar      = dollar_q;
    assign nickel      = nickel_q;
    assign coin_reject = reject_q;
    assign busy        = (state_q == CHANGE);
    assign credit      = credit_q;

endmodule

// File: tb/tb_coin_accum_vend.sv
// Directed bench for coin_accum_vend with hand-computed expectations (default PRICE_UNITS=14).
module tb_coin_accum_vend;

    localparam logic [1:0] NICKEL = 2'b00;
    localparam logic [1:0] DIME   = 2'b01;
    localparam logic [1:0] QTR    = 2'b10;
    localparam logic [1:0] BAD    = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       refund;
    logic       dollar, nickel, coin_reject, busy;
    logic [4:0] credit;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    coin_accum_vend #(.PRICE_UNITS(14), .CREDIT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
`ifdef COIN_REFUND_EN
        .refund      (refund),
`endif
        .dollar      (dollar),
        .nickel      (nickel),
        .coin_reject (coin_reject),
        .busy        (busy),
        .credit      (credit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs for one edge, then sample 1 ns after it.
    task automatic tick(input logic v, input logic [1:0] t, input logic en);
        coin_valid = v;
        coin_type  = t;
        enable     = en;
        @(posedge clk);
        #1;
        check("dollar_nickel_exclusive", {31'd0, dollar & nickel}, 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic d, input logic n, input logic r,
                              input logic b, input logic [4:0] c);
        check({tag, ".dollar"}, {31'd0, dollar}, {31'd0, d});
        check({tag, ".nickel"}, {31'd0, nickel}, {31'd0, n});
        check({tag, ".reject"}, {31'd0, coin_reject}, {31'd0, r});
        check({tag, ".busy"},   {31'd0, busy}, {31'd0, b});
        check({tag, ".credit"}, {27'd0, credit}, {27'd0, c});
    endtask

    initial begin
        int busy_cycles;
        int nickels;
        reset      = 1'b1;
        refund     = 1'b0;
        enable     = 1'b1;
        coin_valid = 1'b1;
        coin_type  = DIME;

        // Reset held two cycles while a coin is presented.
        tick(1'b1, DIME, 1'b1);
        tick(1'b1, DIME, 1'b1);
        expect_out("reset", 0, 0, 0, 0, 5'd0);
        reset = 1'b0;

        // Seven dimes: credit climbs by 2 until the 7th vends exactly.
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, DIME, 1'b1);
            expect_out($sformatf("dime%0d", i), 0, 0, 0, 0, 5'(2 * i));
        end
        tick(1'b1, DIME, 1'b1);
        expect_out("dime7", 1, 0, 0, 0, 5'd0);
        tick(1'b0, NICKEL, 1'b1);
        expect_out("dime7_after", 0, 0, 0, 0, 5'd0);

        // Three quarters: 15 units, one nickel back.
        tick(1'b1, QTR, 1'b1);
        expect_out("qtr1", 0, 0, 0, 0, 5'd5);
        tick(1'b1, QTR, 1'b1);
        expect_out("qtr2", 0, 0, 0, 0, 5'd10);
        tick(1'b1, QTR, 1'b1);
        expect_out("qtr3", 1, 0, 0, 1, 5'd0);
        tick(1'b0, NICKEL, 1'b1);
        expect_out("qtr_change1", 0, 1, 0, 0, 5'd0);
        tick(1'b0, NICKEL, 1'b1);
        expect_out("qtr_idle", 0, 0, 0, 0, 5'd0);

        // Enable low in IDLE: coin ignored, not rejected.
        tick(1'b1, DIME, 1'b0);
        expect_out("disabled_coin", 0, 0, 0, 0, 5'd0);

        // Six dimes + quarter = 17: vend then three nickels, with a stall and a returned dime.
        for (int i = 1; i <= 6; i++) tick(1'b1, DIME, 1'b1);
        check("six_dimes_credit", {27'd0, credit}, 32'd12);
        tick(1'b1, QTR, 1'b1);
        expect_out("q17_vend", 1, 0, 0, 1, 5'd0);
        busy_cycles = 1;
        nickels     = 0;
        tick(1'b0, NICKEL, 1'b1);
        expect_out("q17_n1", 0, 1, 0, 1, 5'd0);
        busy_cycles += int'(busy); nickels += int'(nickel);
        tick(1'b1, DIME, 1'b1);
        expect_out("q17_n2_reject", 0, 1, 1, 1, 5'd0);
        busy_cycles += int'(busy); nickels += int'(nickel);
        tick(1'b0, NICKEL, 1'b0);
        expect_out("q17_stall1", 0, 0, 0, 1, 5'd0);
        busy_cycles += int'(busy); nickels += int'(nickel);
        tick(1'b0, NICKEL, 1'b0);
        expect_out("q17_stall2", 0, 0, 0, 1, 5'd0);
        busy_cycles += int'(busy); nickels += int'(nickel);
        tick(1'b0, NICKEL, 1'b1);
        expect_out("q17_n3", 0, 1, 0, 0, 5'd0);
        busy_cycles += int'(busy); nickels += int'(nickel);
        check("q17_busy_cycles", 32'(busy_cycles), 32'd5);
        check("q17_nickels", 32'(nickels), 32'd3);
        tick(1'b0, NICKEL, 1'b1);
        expect_out("q17_done", 0, 0, 0, 0, 5'd0);

        // Invalid coin type in IDLE is rejected, credit kept.
        tick(1'b1, DIME, 1'b1);
        tick(1'b1, BAD, 1'b1);
        expect_out("bad_coin", 0, 0, 1, 0, 5'd2);
        tick(1'b0, NICKEL, 1'b1);
        expect_out("bad_coin_after", 0, 0, 0, 0, 5'd2);

        // 2 + 5 dimes = 12, quarter -> 17, then reset on the 2nd change cycle.
        for (int i = 1; i <= 5; i++) tick(1'b1, DIME, 1'b1);
        check("pre_reset_credit", {27'd0, credit}, 32'd12);
        tick(1'b1, QTR, 1'b1);
        expect_out("rst_vend", 1, 0, 0, 1, 5'd0);
        tick(1'b0, NICKEL, 1'b1);
        expect_out("rst_n1", 0, 1, 0, 1, 5'd0);
        reset = 1'b1;
        tick(1'b0, NICKEL, 1'b1);
        expect_out("rst_mid_change", 0, 0, 0, 0, 5'd0);
        reset = 1'b0;
        tick(1'b0, NICKEL, 1'b1);
        expect_out("rst_after", 0, 0, 0, 0, 5'd0);
        tick(1'b1, NICKEL, 1'b1);
        expect_out("rst_fresh_coin", 0, 0, 0, 0, 5'd1);

`ifdef COIN_REFUND_EN
        // Credit now 1; add dime+dime -> 5, refund returns five nickels.
        tick(1'b1, DIME, 1'b1);
        tick(1'b1, DIME, 1'b1);
        check("refund_pre_credit", {27'd0, credit}, 32'd5);
        refund = 1'b1;
        tick(1'b1, DIME, 1'b1);
        refund = 1'b0;
        expect_out("refund_req", 0, 0, 1, 1, 5'd0);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b0, NICKEL, 1'b1);
            expect_out($sformatf("refund_n%0d", i), 0, 1, 0, (i < 5) ? 1'b1 : 1'b0, 5'd0);
        end
        tick(1'b0, NICKEL, 1'b1);
        expect_out("refund_done", 0, 0, 0, 0, 5'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
